// File: rtl/pipe_hz_pkg.sv
// Shared types and constants for the pipeline hazard controller: forwarding
// selects, debug state encoding and the per-stage destination tag.
package pipe_hz_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    LU  = 2'd1,
    CR  = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic       valid;
    logic       rf_we;
    logic [4:0] wR;
    logic       is_load;
  } stage_tag_t;

  // A tag can only be a forwarding/hazard source if it really writes a
  // non-zero register; x0 is hardwired and never matches.
  function automatic logic tag_live(input stage_tag_t t);
    return t.valid && t.rf_we && (t.wR != 5'd0);
  endfunction

  function automatic logic tag_hit(input stage_tag_t t, input logic used,
                                   input logic [4:0] rs);
    return used && tag_live(t) && (t.wR == rs);
  endfunction

  // Youngest producer wins so the EX operand always sees the newest value.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                         input stage_tag_t ex_t,
                                         input stage_tag_t mem_t,
                                         input stage_tag_t wb_t);
    if (tag_hit(ex_t, used, rs))       return FWD_EX;
    else if (tag_hit(mem_t, used, rs)) return FWD_MEM;
    else if (tag_hit(wb_t, used, rs))  return FWD_WB;
    else                               return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-side request and hazard/forwarding response bundle between the core
// pipeline (master) and the hazard controller (slave).
interface hazard_ctrl_if #(parameter int CNT_W = 16);

  logic             id_have_inst;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             id_rf_we;
  logic [4:0]       id_wR;
  logic             id_is_load;
  logic             ex_redirect;

  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             Lu_pipeline_stop;
  logic             Cr_pipeline_stop;
  logic [1:0]       fwd_rs1_sel;
  logic [1:0]       fwd_rs2_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       hz_state;

  modport master (
    output id_have_inst, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rf_we, id_wR, id_is_load, ex_redirect,
    input  pc_stall, ifid_stall, ifid_flush, Lu_pipeline_stop,
           Cr_pipeline_stop, fwd_rs1_sel, fwd_rs2_sel, stall_cnt,
           flush_cnt, hz_state
  );

  modport slave (
    input  id_have_inst, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rf_we, id_wR, id_is_load, ex_redirect,
    output pc_stall, ifid_stall, ifid_flush, Lu_pipeline_stop,
           Cr_pipeline_stop, fwd_rs1_sel, fwd_rs2_sel, stall_cnt,
           flush_cnt, hz_state
  );

endinterface

// File: rtl/hz_stage_tag.sv
// One pipeline-stage destination tag: async reset, synchronous clear to a
// bubble (higher priority) and load.
module hz_stage_tag
  import pipe_hz_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       load,
  input  stage_tag_t d,
  output stage_tag_t q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (clear) q <= '0;
    else if (load)  q <= d;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, EX operand
// forwarding selects, saturating event counters and a debug state.
module hazard_ctrl
  import pipe_hz_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_tag_t ex_tag, mem_tag, wb_tag, id_tag;
  logic       lu, cr, lu_stop, bubble;

  hz_state_e        state;
  logic [1:0]       rs1_sel_q, rs2_sel_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  assign id_tag = '{valid:   bus.id_have_inst,
                    rf_we:   bus.id_rf_we,
                    wR:      bus.id_wR,
                    is_load: bus.id_is_load};

  // NOTE: every signal driven from always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    lu = 1'b0;
    cr = 1'b0;
    if (tag_live(ex_tag) && ex_tag.is_load && bus.id_have_inst)
      lu = tag_hit(ex_tag, bus.id_rs1_used, bus.id_rs1) ||
           tag_hit(ex_tag, bus.id_rs2_used, bus.id_rs2);
    cr = bus.ex_redirect && ex_tag.valid;
  end

  // A redirect discards the ID instruction anyway, so it masks the stall.
  assign lu_stop = lu && !cr;
  assign bubble  = lu_stop || cr;

  assign bus.pc_stall         = lu_stop;
  assign bus.ifid_stall       = lu_stop;
  assign bus.Lu_pipeline_stop = lu_stop;
  assign bus.Cr_pipeline_stop = cr;
  assign bus.ifid_flush       = cr;

  hz_stage_tag u_ex_tag (
    .clk(clk), .rst_n(rst_n), .clear(bubble), .load(1'b1),
    .d(id_tag), .q(ex_tag)
  );

  hz_stage_tag u_mem_tag (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .load(1'b1),
    .d(ex_tag), .q(mem_tag)
  );

  hz_stage_tag u_wb_tag (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .load(1'b1),
    .d(mem_tag), .q(wb_tag)
  );

  // Selects are resolved while the consumer is in ID against tags that are
  // one stage ahead, then registered so they line up with EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_sel_q   <= FWD_RF;
      rs2_sel_q   <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      state       <= RUN;
    end else begin
      if (bubble) begin
        rs1_sel_q <= FWD_RF;
        rs2_sel_q <= FWD_RF;
      end else begin
        rs1_sel_q <= fwd_sel(bus.id_rs1_used, bus.id_rs1, ex_tag, mem_tag, wb_tag);
        rs2_sel_q <= fwd_sel(bus.id_rs2_used, bus.id_rs2, ex_tag, mem_tag, wb_tag);
      end

      if (lu_stop && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (cr && flush_cnt_q != CNT_MAX)      flush_cnt_q <= flush_cnt_q + 1'b1;

      if (cr)      state <= CR;
      else if (lu) state <= LU;
      else         state <= RUN;
    end
  end

  assign bus.fwd_rs1_sel = rs1_sel_q;
  assign bus.fwd_rs2_sel = rs2_sel_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.hz_state    = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, redirect, priority,
// counter saturation and asynchronous reset.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic have, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic we,
                       input logic [4:0] wr, input logic ld);
    bus.id_have_inst = have;
    bus.id_rs1       = rs1;
    bus.id_rs1_used  = u1;
    bus.id_rs2       = rs2;
    bus.id_rs2_used  = u2;
    bus.id_rf_we     = we;
    bus.id_wR        = wr;
    bus.id_is_load   = ld;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic check_ctl(input string tag, input logic stall, input logic lu,
                           input logic cr);
    #1;
    check({tag, ".pc_stall"},   bus.pc_stall,         stall);
    check({tag, ".ifid_stall"}, bus.ifid_stall,       stall);
    check({tag, ".ifid_flush"}, bus.ifid_flush,       cr);
    check({tag, ".lu_stop"},    bus.Lu_pipeline_stop, lu);
    check({tag, ".cr_stop"},    bus.Cr_pipeline_stop, cr);
  endtask

  task automatic check_fwd(input string tag, input logic [1:0] s1,
                           input logic [1:0] s2);
    check({tag, ".fwd1"}, bus.fwd_rs1_sel, s1);
    check({tag, ".fwd2"}, bus.fwd_rs2_sel, s2);
  endtask

  task automatic load_use_pair();
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    cyc();
    drive(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.ex_redirect = 1'b0;
    nop();
    cyc();
    cyc();
    check_ctl("reset", 1'b0, 1'b0, 1'b0);
    check_fwd("reset", 2'd0, 2'd0);
    check("reset.stall_cnt", bus.stall_cnt, 0);
    check("reset.flush_cnt", bus.flush_cnt, 0);
    check("reset.hz_state",  bus.hz_state,  0);
    rst_n = 1'b1;

    // Back-to-back loads, each feeding the next: one stall per pair.
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    check_ctl("b2b_first", 1'b0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1);
    check_ctl("b2b_stall1", 1'b1, 1'b1, 1'b0);
    cyc();
    check("b2b.stall_cnt1", bus.stall_cnt, 1);
    check("b2b.state_lu",   bus.hz_state,  1);
    check_ctl("b2b_held", 1'b0, 1'b0, 1'b0);
    cyc();
    check("b2b.fwd_mem", bus.fwd_rs1_sel, 2);
    drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1);
    check_ctl("b2b_stall2", 1'b1, 1'b1, 1'b0);
    cyc();
    check("b2b.stall_cnt2", bus.stall_cnt, 2);
    nop();
    repeat (3) cyc();

    // Independent instructions.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0);
    cyc();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0);
    check_ctl("indep", 1'b0, 1'b0, 1'b0);
    cyc();
    check_fwd("indep", 2'd0, 2'd0);
    check("indep.state", bus.hz_state, 0);

    // ALU dependency chain on x10/x11/x12, plus an x0 read.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b0);
    cyc();
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b1, 1'b1, 5'd11, 1'b0);
    cyc();
    check_fwd("dep_ex", 2'd1, 2'd0);
    drive(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b1, 5'd12, 1'b0);
    cyc();
    check_fwd("dep_mem", 2'd2, 2'd1);
    drive(1'b1, 5'd10, 1'b1, 5'd12, 1'b0, 1'b1, 5'd13, 1'b0);
    cyc();
    check_fwd("dep_wb", 2'd3, 2'd0);
    check("dep.state", bus.hz_state, 0);
    nop();
    repeat (3) cyc();

    // Load-use on x5.
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    cyc();
    drive(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0);
    check_ctl("lu", 1'b1, 1'b1, 1'b0);
    cyc();
    check("lu.state",     bus.hz_state,  1);
    check("lu.stall_cnt", bus.stall_cnt, 3);
    check_fwd("lu_bubble", 2'd0, 2'd0);
    check_ctl("lu_release", 1'b0, 1'b0, 1'b0);
    cyc();
    check_fwd("lu_ex", 2'd2, 2'd0);
    check("lu.state_run", bus.hz_state,  0);
    check("lu.stall_cnt", bus.stall_cnt, 3);
    nop();
    repeat (3) cyc();

    // Taken branch in EX.
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0);
    cyc();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0);
    bus.ex_redirect = 1'b1;
    check_ctl("cr", 1'b0, 1'b0, 1'b1);
    cyc();
    bus.ex_redirect = 1'b0;
    check("cr.state",     bus.hz_state,  2);
    check("cr.flush_cnt", bus.flush_cnt, 1);
    drive(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b0);
    cyc();
    check_fwd("cr_killed", 2'd0, 2'd0);
    check("cr.state_run", bus.hz_state, 0);
    nop();
    repeat (3) cyc();

    // Redirect with no valid instruction in EX is ignored.
    bus.ex_redirect = 1'b1;
    check_ctl("cr_invalid", 1'b0, 1'b0, 1'b0);
    cyc();
    bus.ex_redirect = 1'b0;
    check("cr_invalid.flush_cnt", bus.flush_cnt, 1);
    check("cr_invalid.state",     bus.hz_state,  0);

    // Redirect concurrent with load-use: redirect wins.
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    cyc();
    drive(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0);
    bus.ex_redirect = 1'b1;
    check_ctl("lu_cr", 1'b0, 1'b0, 1'b1);
    cyc();
    bus.ex_redirect = 1'b0;
    check("lu_cr.stall_cnt", bus.stall_cnt, 3);
    check("lu_cr.flush_cnt", bus.flush_cnt, 2);
    check("lu_cr.state",     bus.hz_state,  2);
    nop();
    repeat (3) cyc();

    // Saturation: 19 more stalls from 3 pin the 4-bit counter at 15.
    repeat (11) load_use_pair();
    check("sat.stall_cnt14", bus.stall_cnt, 14);
    repeat (8) load_use_pair();
    check("sat.stall_cnt15", bus.stall_cnt, 15);
    check("sat.flush_cnt",   bus.flush_cnt, 2);

    // Asynchronous reset in the middle of a stall.
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    cyc();
    drive(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0);
    check_ctl("rst_pre", 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    check_ctl("rst_mid", 1'b0, 1'b0, 1'b0);
    check_fwd("rst_mid", 2'd0, 2'd0);
    check("rst_mid.stall_cnt", bus.stall_cnt, 0);
    check("rst_mid.flush_cnt", bus.flush_cnt, 0);
    check("rst_mid.state",     bus.hz_state,  0);
    cyc();
    rst_n = 1'b1;
    check_ctl("rst_post", 1'b0, 1'b0, 1'b0);
    cyc();
    check("rst_post.state",     bus.hz_state,  0);
    check("rst_post.stall_cnt", bus.stall_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and tracks destination-register tags for the EX, MEM and WB stages. From those tags it generates:
- load-use stall and control-redirect flush, including `Lu_pipeline_stop` and `Cr_pipeline_stop` that clear ID/EX;
- PC/IF-ID hold and IF-ID flush;
- operand forwarding selects for EX.

It also keeps saturating stall/flush event counters and a debug state.

## Interface
Parameters:
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- id_have_inst  in  1  ID holds a valid instruction.
- id_rs1, id_rs2  in  5 each  ID source register indices.
- id_rs1_used, id_rs2_used  in  1 each  instruction actually reads rs1/rs2.
- id_rf_we  in  1  ID instruction writes the register file.
- id_wR  in  5  ID destination register index.
- id_is_load  in  1  ID instruction is a load (wd_sel = DRAM).
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  clear IF/ID to a bubble.
- Lu_pipeline_stop  out  1  load-use bubble into ID/EX.
- Cr_pipeline_stop  out  1  control bubble into ID/EX.
- fwd_rs1_sel, fwd_rs2_sel  out  2 each  EX operand source: 0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB write data, 3 = WB-stage write data.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  redirect flushes, saturating.
- hz_state  out  2  last-cycle event: 0 RUN, 1 LU, 2 CR.

## Operation
- Stage tags: EX, MEM and WB each hold {valid, rf_we, wR, is_load}.
- A tag is live only if valid && rf_we && wR != 0. Register x0 never matches.
- Tag registers model the pipeline registers one-to-one:
  - The EX tag is loaded from the ID inputs (valid = id_have_inst).
  - The EX tag becomes all-zero when Lu_pipeline_stop or Cr_pipeline_stop is 1.
  - The MEM tag is loaded from EX; the WB tag is loaded from MEM.
- Forwarding (tags are one stage ahead of the operands they serve):
  - For each used source, priority is EX tag (sel 1) > MEM tag (sel 2) > WB tag (sel 3) > 0.
  - Selects are registered: the value computed from the ID inputs is presented in the cycle the instruction occupies EX.
  - Selects are 0 whenever a bubble is inserted.
- Load-use (lu): the EX tag is live, is_load = 1, id_have_inst = 1, and wR matches a used ID source.
  - Asserts pc_stall, ifid_stall and Lu_pipeline_stop for exactly one cycle.
  - The next cycle the load is in MEM, so no repeat stall occurs.
- Control (cr): ex_redirect && EX tag valid.
  - Asserts Cr_pipeline_stop and ifid_flush.
  - pc_stall = 0, so the PC loads the redirect target.
  - ex_redirect with an invalid EX tag is ignored.
- Simultaneous lu and cr: cr wins. Lu_pipeline_stop, pc_stall and ifid_stall are 0; only flush_cnt increments.
- FSM (hz_state), evaluated on every clock edge:
  - Enter CR if cr, else LU if lu, else RUN.
  - Reachable from any state.
- Counters:
  - stall_cnt increments on each lu cycle (not overridden by cr).
  - flush_cnt increments on each cr cycle.
  - Both saturate at 2^CNT_W−1.

## Timing
- pc_stall, ifid_stall, ifid_flush, Lu_pipeline_stop and Cr_pipeline_stop are combinational from the current tags and inputs. They take effect at the same clock edge.
- Tags, forwarding selects, counters and hz_state are registered, with one-cycle latency.
- Reset values (asynchronous):
  - All tags invalid/zero.
  - fwd_rs1_sel = fwd_rs2_sel = 0.
  - stall_cnt = flush_cnt = 0.
  - hz_state = RUN.
  - All combinational outputs evaluate to 0 (tags are invalid).
- Reset asserted mid-stall clears everything immediately. The first cycle after release is RUN.
- Back-to-back loads each feeding the next cause one stall per pair. Separate stall events are never merged.

## Structure
- Shared package pipe_hz_pkg holds:
  - forwarding constants FWD_RF / FWD_EX / FWD_MEM / FWD_WB;
  - hz_state encoding RUN / LU / CR;
  - the stage-tag struct {valid, rf_we, wR, is_load}.
- Sub-module hz_stage_tag: one tag register with async reset, a synchronous clear-to-bubble input and load. It is instantiated three times.

## Test plan
- Independent instructions: ADD x5; then ADD x6 reading x1/x2 → no stall. fwd sels 0; hz_state stays RUN.
- ALU dependency: ADD x5; then SUB x7 reading x5 → SUB in EX sees fwd_rs1_sel = 1. One instruction later a reader sees sel 2, two later sel 3. Reads of x0 always give 0.
- Load-use: LW x5; then ADD reading x5 → one cycle of pc_stall = ifid_stall = Lu_pipeline_stop = 1. The ADD then enters EX with fwd_rs1_sel = 2. stall_cnt = 1, hz_state LU then RUN.
- Redirect: branch in EX with ex_redirect = 1 → Cr_pipeline_stop = ifid_flush = 1 and pc_stall = 0. The next EX tag is invalid; flush_cnt = 1.
- Redirect concurrent with load-use → cr only: Lu_pipeline_stop = 0, stall_cnt unchanged, flush_cnt + 1. Also: ex_redirect with an invalid EX tag → no outputs.
- Saturation and reset: force 2^CNT_W + 3 stalls → stall_cnt = all-ones. Assert rst_n low mid-stall → all outputs 0 asynchronously.
